// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says game sequencer.
package simon_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLEAR    = 3'd1,
      PLAYBACK = 3'd2,
      INPUT    = 3'd3,
      WIN      = 3'd4,
      LOSE     = 3'd5
   } state_t;

   localparam logic [3:0] LEVEL_OFF = 4'd15;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } btn_dec_t;

   // Only a single pressed button yields a valid colour index.
   function automatic btn_dec_t decode_buttons(input logic [3:0] b);
      btn_dec_t d;
      d.valid = 1'b1;
      d.idx   = 2'd0;
      case (b)
         4'b0001: d.idx = 2'd0;
         4'b0010: d.idx = 2'd1;
         4'b0100: d.idx = 2'd2;
         4'b1000: d.idx = 2'd3;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers the previous sample, flags 0->1 transitions.
module edge_detect #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sig,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] sig_q_r;

   // History of the input, updated every cycle regardless of consumer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q_r <= {WIDTH{1'b0}};
      end else begin
         sig_q_r <= sig;
      end
   end

   assign rise = sig & ~sig_q_r;

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: drives the blinker, checks player entry against
// the sequence memory, and tracks level/score through to WIN or LOSE.
module simon_game_ctrl
   import simon_pkg::*;
#(
   parameter int unsigned ms            = 1_000_000,
   parameter int unsigned TIMEOUT_UNITS = 250,
   parameter int unsigned MAX_LEVEL     = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] buttons,
   input  logic       blink_done,
   input  logic [3:0] blink_count,
   input  logic [1:0] mem_data,
   output logic       on_off,
   output logic [3:0] level,
   output logic [3:0] mem_addr,
   output logic [3:0] score,
   output logic       win,
   output logic       lose
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_UNITS * ms - 32'd1);
   localparam logic [3:0]  MAX_LEVEL_L  = 4'(MAX_LEVEL);

   state_t      state_r;
   logic [3:0]  level_r;
   logic [3:0]  score_r;
   logic [3:0]  index_r;
   logic [31:0] timer_r;
   logic        on_off_r;
   logic        win_r;
   logic        lose_r;

   logic        start_rise_s;
   logic        press_s;
   logic        btn_any_s;
   btn_dec_t    dec_s;
   logic        match_s;
   logic        last_s;

   assign btn_any_s = |buttons;

   edge_detect #(.WIDTH(1)) u_start_edge (
      .clk   (clk),
      .rst_n (reset),
      .sig   (start),
      .rise  (start_rise_s)
   );

   // A press only registers when all buttons were released the cycle before.
   edge_detect #(.WIDTH(1)) u_press_edge (
      .clk   (clk),
      .rst_n (reset),
      .sig   (btn_any_s),
      .rise  (press_s)
   );

   assign dec_s   = decode_buttons(buttons);
   assign match_s = dec_s.valid && (dec_s.idx == mem_data);
   assign last_s  = (index_r == (level_r - 4'd1));

   assign mem_addr = (state_r == PLAYBACK) ? blink_count : index_r;
   assign on_off   = on_off_r;
   assign level    = level_r;
   assign score    = score_r;
   assign win      = win_r;
   assign lose     = lose_r;

   // Game FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         level_r  <= LEVEL_OFF;
         score_r  <= 4'd0;
         index_r  <= 4'd0;
         timer_r  <= 32'd0;
         on_off_r <= 1'b0;
         win_r    <= 1'b0;
         lose_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               on_off_r <= 1'b0;
               level_r  <= LEVEL_OFF;
               if (start_rise_s) begin
                  state_r <= CLEAR;
                  level_r <= 4'd1;
                  score_r <= 4'd0;
               end
            end
            // One idle cycle lets the blinker flush its count and done.
            CLEAR: begin
               on_off_r <= 1'b1;
               state_r  <= PLAYBACK;
            end
            PLAYBACK: begin
               if (blink_done) begin
                  state_r  <= INPUT;
                  on_off_r <= 1'b0;
                  index_r  <= 4'd0;
                  timer_r  <= 32'd0;
               end
            end
            INPUT: begin
               if (press_s) begin
                  if (!match_s) begin
                     state_r <= LOSE;
                     lose_r  <= 1'b1;
                     level_r <= LEVEL_OFF;
                  end else if (!last_s) begin
                     index_r <= index_r + 4'd1;
                     timer_r <= 32'd0;
                  end else if (level_r == MAX_LEVEL_L) begin
                     state_r <= WIN;
                     win_r   <= 1'b1;
                     score_r <= level_r;
                     level_r <= LEVEL_OFF;
                  end else begin
                     state_r <= CLEAR;
                     score_r <= level_r;
                     level_r <= level_r + 4'd1;
                  end
               end else if (timer_r == TIMEOUT_LAST) begin
                  state_r <= LOSE;
                  lose_r  <= 1'b1;
                  level_r <= LEVEL_OFF;
               end else begin
                  timer_r <= timer_r + 32'd1;
               end
            end
            WIN, LOSE: begin
               on_off_r <= 1'b0;
               if (start_rise_s) begin
                  state_r <= CLEAR;
                  level_r <= 4'd1;
                  score_r <= 4'd0;
                  win_r   <= 1'b0;
                  lose_r  <= 1'b0;
               end
            end
            default: begin
               state_r  <= IDLE;
               level_r  <= LEVEL_OFF;
               on_off_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
- Top-level game sequencer for Simon Says. Drives the blinker through on_off and level, and waits for its done. Then collects player button presses and compares each press against the sequence memory.
- Advances level on a correct round; ends in WIN or LOSE.
- Owns the sequence-memory address mux: the blinker count during playback, its own input index during entry.

Parameters:
- ms, 1_000_000, clock cycles per time unit (matches blinker).
- TIMEOUT_UNITS, 250, player input timeout in ms units (250*ms cycles = 5 s at 50 MHz).
- MAX_LEVEL, 9, last playable level; must be < 10.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  synchronous level; a rising edge starts or restarts a game.
- buttons  in  4  player buttons, already debounced and synchronous, 1 = pressed.
- blink_done  in  1  blinker done.
- blink_count  in  4  blinker count (its memory address).
- mem_data  in  2  sequence memory read data; combinational, valid the same cycle as mem_addr.
- on_off  out  1  blinker enable.
- level  out  4  current level to blinker; 15 = blinker disabled.
- mem_addr  out  4  sequence memory address.
- score  out  4  rounds completed in the current game.
- win  out  1  held high in WIN.
- lose  out  1  held high in LOSE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, level=15, on_off=0, mem_addr=0, score=0, win=0, lose=0.
  - input index=0, timer=0, start/button history registers=0.
- Edge detection:
  - start_rise = start & ~start_q.
  - press = (buttons != 0) & (buttons_q == 0); history is updated every cycle in every state.
  - A button held across a state change never counts as a new press.
- Press decode:
  - 0001->0, 0010->1, 0100->2, 1000->3.
  - A non-one-hot press value is a mismatch.
- mem_addr = blink_count in PLAYBACK, input index in all other states (registered index, combinational mux).
- IDLE:
  - level=15, on_off=0.
  - start_rise -> CLEAR with level=1, score=0.
- CLEAR:
  - Exactly one cycle with on_off=0 and level held; this flushes blinker count/done.
  - -> PLAYBACK.
- PLAYBACK:
  - on_off=1.
  - blink_done=1 -> INPUT, with on_off=0 the same edge, index=0, timer=0.
  - Presses are ignored.
- INPUT:
  - on_off=0; timer increments each cycle.
  - On press, compare decode against mem_data in the same cycle:
    - match, index < level-1 -> index+1, timer=0, stay.
    - match, index == level-1, level == MAX_LEVEL -> WIN, score=level.
    - match, index == level-1, otherwise -> score=level, level+1, -> CLEAR.
    - mismatch -> LOSE.
  - timer reaching TIMEOUT_UNITS*ms-1 with no press -> LOSE.
  - Press and timeout in the same cycle: the press wins.
- WIN: win=1, level=15, on_off=0. start_rise -> CLEAR with level=1, score=0, win cleared.
- LOSE: lose=1, level=15, on_off=0, score frozen. start_rise restarts exactly as in WIN.
- start_rise in CLEAR, PLAYBACK or INPUT is ignored.
- Mid-game reset returns to IDLE immediately. The blinker sees level=15 and clears itself.
- Arithmetic widths:
  - Timer is 32-bit unsigned.
  - index and level are 4-bit; level never exceeds MAX_LEVEL while on_off=1.

Decomposition:
- Package simon_pkg:
  - state enum typedef: IDLE, CLEAR, PLAYBACK, INPUT, WIN, LOSE.
  - LEVEL_OFF=4'd15.
  - Button-decode function (one-hot to index plus valid flag).
- One sub-module: edge_detect (registered rising-edge detector, width parameter), instantiated for start and for the button-any signal.

Test Plan (ms=1, TIMEOUT_UNITS=20, MAX_LEVEL=3, behavioural blinker and memory holding sequence 2,0,3):
- Reset held, then start pulse:
  - level=1 and on_off=0 for one cycle, then on_off=1.
  - mem_addr follows blink_count.
  - on blink_done, on_off=0 and mem_addr=0.
- Level 1, press 0100: level=2 after one CLEAR cycle, score=1. Level 2, press 0100 then 0001: level=3, score=2.
- Level 3, press 0100, 0001, 1000: win=1, level=15, score=3. Start pulse: win=0, level=1, score=0.
- Level 2, press 0100 then 0010: lose=1, level=15, score stays 1.
- INPUT with no press: lose=1 exactly 20 cycles after INPUT entry. Press on the 20th cycle: accepted, no lose.
- Robustness:
  - Button held from PLAYBACK into INPUT: not counted.
  - Press 0110: lose.
  - start during PLAYBACK: ignored.
  - reset low mid-INPUT: all outputs at reset values asynchronously.
